lfsr_rng: RTL and testbench

//  Parametrised XNOR Fibonacci LFSR with a bounded-range random draw engine. It replaces the fixed 7-bit LFSR.

---
 rtl/lfsr_rng.sv | 119 +++++++++++
 tb/tb_lfsr_rng.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - XNOR Fibonacci LFSR with bounded-range rejection-sampling draw engine
//
// Purpose:
//   Free-running XNOR Fibonacci LFSR. A req/valid draw engine returns a value in
//   [MIN_VAL, MIN_VAL+RANGE-1] by rejecting LFSR states >= RANGE. A watchdog gives up
//   after MAX_TRIES rejections and reports err, with num forced to MIN_VAL.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   seed_load  load seed_in into the LFSR on this edge (overrides the step)
//   seed_in    seed value; all-ones is replaced by all-zeros
//   req        draw request, sampled only in IDLE
//   busy       high while a draw is being searched
//   valid      one-cycle pulse: num holds a new draw
//   err        one-cycle pulse: watchdog expired, num = MIN_VAL
//   num        last drawn value, held until the next draw
//   lfsr_q     raw LFSR state
module lfsr_rng #(
    parameter int               WIDTH     = 7,
    parameter logic [WIDTH-1:0] TAPS      = 7'b1100000,
    parameter logic [WIDTH-1:0] SEED      = '0,
    parameter int               RANGE     = 100,
    parameter int               MIN_VAL   = 1,
    parameter int               MAX_TRIES = 2**WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               seed_load,
    input  logic [WIDTH-1:0]                   seed_in,
    input  logic                               req,
    output logic                               busy,
    output logic                               valid,
    output logic                               err,
    output logic [$clog2(MIN_VAL+RANGE)-1:0]   num,
    output logic [WIDTH-1:0]                   lfsr_q
);

    localparam int NW = $clog2(MIN_VAL + RANGE);
    // Counter only has to hold 0..MAX_TRIES-1.
    localparam int CW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SEARCH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    try_q, try_d;
    logic [NW-1:0]    num_q, num_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] lfsr_d;
    logic             fb;

    always_comb begin
        // XNOR feedback keeps all-zeros legal; all-ones is the lock-up state and is
        // never produced by the step or by a seed load.
        fb = ~^(lfsr_q & TAPS);
        if (seed_load) begin
            lfsr_d = (seed_in == {WIDTH{1'b1}}) ? '0 : seed_in;
        end else begin
            lfsr_d = {lfsr_q[WIDTH-2:0], fb};
        end

        state_d = state_q;
        try_d   = try_q;
        num_d   = num_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SEARCH;
                    try_d   = '0;
                end
            end
            ST_SEARCH: begin
                // Evaluate the current state; a seed loaded this cycle is seen next cycle.
                if (lfsr_q < WIDTH'(RANGE)) begin
                    // lfsr_q < RANGE, so the offset sum fits num without wrapping.
                    num_d   = NW'(lfsr_q) + NW'(MIN_VAL);
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (try_q == CW'(MAX_TRIES - 1)) begin
                    num_d   = NW'(MIN_VAL);
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    try_d = try_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= SEED;
            state_q <= ST_IDLE;
            try_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            try_q   <= try_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q == ST_SEARCH);
    assign valid = valid_q;
    assign err   = err_q;
    assign num   = num_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng (default build and RANGE=1/MAX_TRIES=4 build)
module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       seed_load = 1'b0;
    logic [6:0] seed_in = '0;
    logic       req = 1'b0;
    logic       busy, valid, err;
    logic [6:0] num;
    logic [6:0] lfsr_q;

    logic       r2_reset = 1'b1;
    logic       r2_seed_load = 1'b0;
    logic [6:0] r2_seed_in = '0;
    logic       r2_req = 1'b0;
    logic       r2_busy, r2_valid, r2_err;
    logic [0:0] r2_num;
    logic [6:0] r2_lfsr;

    int tests = 0;
    int fails = 0;
    int m_lfsr = 0;

    always #5 clk = ~clk;

    lfsr_rng dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
        .busy(busy), .valid(valid), .err(err), .num(num), .lfsr_q(lfsr_q)
    );

    lfsr_rng #(.RANGE(1), .MAX_TRIES(4)) dut2 (
        .clk(clk), .reset(r2_reset), .seed_load(r2_seed_load), .seed_in(r2_seed_in), .req(r2_req),
        .busy(r2_busy), .valid(r2_valid), .err(r2_err), .num(r2_num), .lfsr_q(r2_lfsr)
    );

    // Reference step: shift left in 7 bits, feedback is 1 when an even number of tap bits are set.
    function automatic int step(input int s);
        logic [6:0] v;
        v = 7'(s);
        return ((s * 2) % 128) + ((($countones(v & 7'h60) % 2) == 0) ? 1 : 0);
    endfunction

    function automatic int load_val(input int v);
        return (v == 127) ? 0 : v;
    endfunction

    // Walk the sequence from the first evaluated value: number of rejections and whether the
    // watchdog fires (which happens on rejection number 'tries').
    function automatic void predict(input int start, input int range, input int tries,
                                    output int rej, output bit is_err);
        int s;
        s = start;
        rej = 0;
        is_err = 1'b0;
        for (int k = 0; k < tries; k++) begin
            if (s < range) return;
            rej++;
            s = step(s);
        end
        is_err = 1'b1;
    endfunction

    task automatic tick();
        m_lfsr = reset ? 0 : (seed_load ? load_val(int'(seed_in)) : step(m_lfsr));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp_seq [8];
        exp_seq = '{7'd1, 7'd3, 7'd7, 7'd15, 7'd31, 7'd63, 7'd126, 7'd125};
        reset = 1'b1; r2_reset = 1'b1;
        tick(); tick();
        tests++;
        if ({busy, valid, err} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: busy/valid/err=%b expected 000", {busy, valid, err});
        end
        tests++;
        if (num !== 7'd0) begin fails++; $display("FAIL reset_num: got %0d expected 0", num); end
        tests++;
        if (lfsr_q !== 7'd0) begin fails++; $display("FAIL reset_lfsr: got %0d expected 0", lfsr_q); end
        reset = 1'b0; r2_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (lfsr_q !== exp_seq[i] || lfsr_q !== 7'(m_lfsr)) begin
                fails++; $display("FAIL free_run[%0d]: got %0d expected %0d", i, lfsr_q, exp_seq[i]);
            end
            tests++;
            if ({busy, valid, err} !== 3'b000) begin
                fails++; $display("FAIL free_run_flags[%0d]: got %b expected 000", i, {busy, valid, err});
            end
        end
    endtask

    task automatic test_seed_req();
        seed_load = 1'b1; seed_in = 7'd42; req = 1'b1;
        tick();
        seed_load = 1'b0; req = 1'b0;
        tests++;
        if (lfsr_q !== 7'd42 || busy !== 1'b1 || valid !== 1'b0) begin
            fails++; $display("FAIL seed_req_start: lfsr=%0d busy=%b valid=%b expected 42 1 0", lfsr_q, busy, valid);
        end
        tick();
        tests++;
        if (valid !== 1'b1 || num !== 7'd43 || busy !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL seed_req_draw: valid=%b num=%0d busy=%b err=%b expected 1 43 0 0", valid, num, busy, err);
        end
        tick();
        tests++;
        if (valid !== 1'b0) begin fails++; $display("FAIL seed_req_pulse: valid=%b expected 0", valid); end
    endtask

    task automatic test_reject();
        seed_load = 1'b1; seed_in = 7'd110; req = 1'b1;
        tick();
        seed_load = 1'b0; req = 1'b0;
        tick();
        tests++;
        if (valid !== 1'b0 || busy !== 1'b1 || lfsr_q !== 7'd93) begin
            fails++; $display("FAIL reject_step: valid=%b busy=%b lfsr=%0d expected 0 1 93", valid, busy, lfsr_q);
        end
        tick();
        tests++;
        if (valid !== 1'b1 || num !== 7'd94) begin
            fails++; $display("FAIL reject_draw: valid=%b num=%0d expected 1 94", valid, num);
        end
    endtask

    task automatic test_seed_allones();
        seed_load = 1'b1; seed_in = 7'd127;
        tick();
        seed_load = 1'b0;
        tests++;
        if (lfsr_q !== 7'd0) begin fails++; $display("FAIL allones_load: got %0d expected 0", lfsr_q); end
        tick();
        tests++;
        if (lfsr_q !== 7'd1) begin fails++; $display("FAIL allones_step: got %0d expected 1", lfsr_q); end
    endtask

    task automatic test_req_held();
        int n_valid;
        int n_err;
        // Seed 126 gives 5 rejections (126,125,123,119,111) then accepts 95.
        n_valid = 0;
        seed_load = 1'b1; seed_in = 7'd126; req = 1'b1;
        tick();
        seed_load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) req = 1'b0;
            tick();
            if (valid === 1'b1) begin
                n_valid++;
                tests++;
                if (i != 6 || num !== 7'd96) begin
                    fails++; $display("FAIL held_draw: valid at tick %0d num=%0d expected tick 6 num 96", i, num);
                end
            end
        end
        tests++;
        if (n_valid != 1) begin fails++; $display("FAIL held_count: %0d valid pulses expected 1", n_valid); end

        // Reset in the middle of a search aborts it silently.
        seed_load = 1'b1; seed_in = 7'd126; req = 1'b1;
        tick();
        seed_load = 1'b0; req = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({busy, valid, err} !== 3'b000 || num !== 7'd0 || lfsr_q !== 7'(m_lfsr)) begin
            fails++; $display("FAIL midsearch_reset: bve=%b num=%0d lfsr=%0d expected 000 0 %0d", {busy, valid, err}, num, lfsr_q, m_lfsr);
        end
        n_valid = 0; n_err = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid === 1'b1) n_valid++;
            if (err === 1'b1) n_err++;
        end
        tests++;
        if (n_valid != 0 || n_err != 0) begin
            fails++; $display("FAIL midsearch_quiet: valid=%0d err=%0d pulses expected 0 0", n_valid, n_err);
        end
    endtask

    task automatic test_back_to_back();
        int rej;
        bit is_err;
        int gap;
        for (int n = 0; n < 25; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                tests++;
                if (lfsr_q !== 7'(m_lfsr) || busy !== 1'b0) begin
                    fails++; $display("FAIL rand_idle[%0d]: lfsr=%0d busy=%b expected %0d 0", n, lfsr_q, busy, m_lfsr);
                end
            end
            seed_load = ($urandom_range(0, 1) == 1);
            seed_in = 7'($urandom_range(0, 127));
            req = 1'b1;
            tick();
            seed_load = 1'b0;
            predict(m_lfsr, 100, 128, rej, is_err);
            for (int k = 0; k < rej; k++) begin
                req = ($urandom_range(0, 1) == 1);
                tick();
                tests++;
                if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b1 || lfsr_q !== 7'(m_lfsr)) begin
                    fails++; $display("FAIL rand_search[%0d.%0d]: v=%b e=%b b=%b lfsr=%0d expected 0 0 1 %0d", n, k, valid, err, busy, lfsr_q, m_lfsr);
                end
            end
            req = ($urandom_range(0, 1) == 1);
            tick();
            req = 1'b0;
            tests++;
            if (is_err) begin
                if (err !== 1'b1 || valid !== 1'b0 || num !== 7'd1) begin
                    fails++; $display("FAIL rand_err[%0d]: err=%b valid=%b num=%0d expected 1 0 1", n, err, valid, num);
                end
            end else begin
                // The accepted value is the state evaluated on this final search cycle.
                if (valid !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
                    fails++; $display("FAIL rand_draw[%0d]: valid=%b err=%b busy=%b expected 1 0 0", n, valid, err, busy);
                end
            end
            if (!is_err) begin
                int acc;
                acc = m_lfsr;
                // m_lfsr has advanced once past the accepted value; recover it by walking from the start.
                tests++;
                if (int'(num) < 1 || int'(num) > 100 || step(int'(num) - 1) != acc) begin
                    fails++; $display("FAIL rand_num[%0d]: num=%0d not consistent with lfsr %0d", n, num, acc);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int rej;
        bit is_err;
        predict(5, 1, 4, rej, is_err);
        r2_seed_load = 1'b1; r2_seed_in = 7'd5; r2_req = 1'b1;
        tick();
        r2_seed_load = 1'b0; r2_req = 1'b0;
        for (int k = 1; k < rej; k++) begin
            tick();
            tests++;
            if (r2_err !== 1'b0 || r2_valid !== 1'b0 || r2_busy !== 1'b1) begin
                fails++; $display("FAIL wd_search[%0d]: err=%b valid=%b busy=%b expected 0 0 1", k, r2_err, r2_valid, r2_busy);
            end
        end
        tick();
        tests++;
        if (!is_err || rej != 4 || r2_err !== 1'b1 || r2_valid !== 1'b0 || r2_num !== 1'b1) begin
            fails++; $display("FAIL wd_fire: err=%b valid=%b num=%0d expected 1 0 1", r2_err, r2_valid, r2_num);
        end
        tick();
        tests++;
        if (r2_err !== 1'b0 || r2_busy !== 1'b0 || r2_valid !== 1'b0) begin
            fails++; $display("FAIL wd_after: err=%b busy=%b valid=%b expected 0 0 0", r2_err, r2_busy, r2_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_seed_req();
        test_reject();
        test_seed_allones();
        test_req_held();
        test_back_to_back();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
